// File: rtl/ysyx_22040386_pkg.sv
// Shared constants and FSM encoding for the NPC fetch/PC stage.
package ysyx_22040386_pkg;

  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] RESET_PC   = 64'h0000_0000_8000_0000;
  localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } pc_state_t;

endpackage

// File: rtl/ysyx_22040386_pc_target.sv
// Redirect target adder with JALR LSB clear and 4-byte misalignment flag.
// Latency: purely combinational; no backpressure (no handshake).
module ysyx_22040386_pc_target
  import ysyx_22040386_pkg::*;
(
  input  logic            jalr,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] imm_ex,
  input  logic [XLEN-1:0] rs1_ex,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;

  assign base     = jalr ? rs1_ex : pc_ex;
  assign sum      = base + imm_ex;
  assign target   = jalr ? {sum[XLEN-1:1], 1'b0} : sum;
  assign misalign = |target[1:0];

endmodule

// File: rtl/ysyx_22040386_pc_unit.sv
// Fetch PC register, IFU req/ack FSM, redirect buffer, flush/misalign pulses.
// Latency: taken -> target address 1 cycle after the consuming edge; stall or missing ack holds pc and buffers redirects.
module ysyx_22040386_pc_unit
  import ysyx_22040386_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            Branch,
  input  logic            Jalr,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] imm_ex,
  input  logic [XLEN-1:0] rs1_ex,
  input  logic            stall,
  input  logic            ifu_ack,
  output logic            ifu_req,
  output logic [XLEN-1:0] ifu_addr,
  output logic [XLEN-1:0] pc,
  output logic            flush,
  output logic            misalign
);

  pc_state_t       state;
  pc_state_t       state_nxt;
  logic            pc_upd;
  logic            taken;
  logic            tgt_mis;
  logic [XLEN-1:0] target;
  logic            redir_v;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] next_seq;
  logic [XLEN-1:0] pc_nxt;

  ysyx_22040386_pc_target u_target (
    .jalr     (Jalr),
    .pc_ex    (pc_ex),
    .imm_ex   (imm_ex),
    .rs1_ex   (rs1_ex),
    .target   (target),
    .misalign (tgt_mis)
  );

  assign taken    = ex_valid & Branch;
  assign next_seq = redir_v ? redir_pc : pc + INST_BYTES;
  assign pc_nxt   = taken ? target : next_seq;
  assign ifu_req  = (state == REQ);
  assign ifu_addr = pc;

  always_comb begin
    state_nxt = state;
    pc_upd    = 1'b0;
    case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        // An acked fetch under stall is kept; pc waits in HOLD until release.
        if (ifu_ack) begin
          if (stall) state_nxt = HOLD;
          else       pc_upd    = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          state_nxt = REQ;
          pc_upd    = 1'b1;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      redir_v  <= 1'b0;
      redir_pc <= RESET_PC;
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      flush    <= taken;
      misalign <= taken & tgt_mis;
      if (pc_upd) begin
        pc      <= pc_nxt;
        redir_v <= 1'b0;
      end else if (taken) begin
        redir_v  <= 1'b1;
        redir_pc <= target;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040386_pc_unit.sv
// Directed table-driven bench for the PC unit; each row is one clock edge.
module tb_ysyx_22040386_pc_unit;
  import ysyx_22040386_pkg::*;

  typedef struct {
    logic            rst, ev, br, jr, st, ack;
    logic [XLEN-1:0] pc_ex, imm, rs1;
    logic            req;
    logic [XLEN-1:0] addr;
    logic            fl, mis;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst, ex_valid, Branch, Jalr, stall, ifu_ack;
  logic [XLEN-1:0] pc_ex, imm_ex, rs1_ex;
  logic            ifu_req, flush, misalign;
  logic [XLEN-1:0] ifu_addr, pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_22040386_pc_unit dut (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (ex_valid),
    .Branch   (Branch),
    .Jalr     (Jalr),
    .pc_ex    (pc_ex),
    .imm_ex   (imm_ex),
    .rs1_ex   (rs1_ex),
    .stall    (stall),
    .ifu_ack  (ifu_ack),
    .ifu_req  (ifu_req),
    .ifu_addr (ifu_addr),
    .pc       (pc),
    .flush    (flush),
    .misalign (misalign)
  );

  function automatic vec_t mk(input logic r, ev, br, jr, st, ack,
                              input logic [XLEN-1:0] pcx, im, r1,
                              input logic req, input logic [XLEN-1:0] addr,
                              input logic fl, mis);
    vec_t v;
    v.rst = r;  v.ev = ev;  v.br = br;   v.jr = jr;  v.st = st; v.ack = ack;
    v.pc_ex = pcx; v.imm = im; v.rs1 = r1;
    v.req = req; v.addr = addr; v.fl = fl; v.mis = mis;
    return v;
  endfunction

  task automatic check(input string nm, input int row, input logic [XLEN-1:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  // Drive away from the active edge, sample 1 time unit after it.
  task automatic run_vec(input vec_t v, input int row);
    @(negedge clk);
    rst = v.rst; ex_valid = v.ev; Branch = v.br; Jalr = v.jr;
    stall = v.st; ifu_ack = v.ack;
    pc_ex = v.pc_ex; imm_ex = v.imm; rs1_ex = v.rs1;
    @(posedge clk);
    #1;
    check("ifu_req",  row, XLEN'(ifu_req),  XLEN'(v.req));
    check("ifu_addr", row, ifu_addr,        v.addr);
    check("pc",       row, pc,              v.addr);
    check("flush",    row, XLEN'(flush),    XLEN'(v.fl));
    check("misalign", row, XLEN'(misalign), XLEN'(v.mis));
  endtask

  localparam logic [XLEN-1:0] B = 64'h8000_0000;
  localparam logic [XLEN-1:0] Z = '0;

  vec_t tbl[30];
  vec_t seq[10];

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; Branch = 1'b0; Jalr = 1'b0;
    stall = 1'b0; ifu_ack = 1'b0; pc_ex = '0; imm_ex = '0; rs1_ex = '0;

    //            rst ev br jr st ack pc_ex                  imm                    rs1            req addr          fl mis
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, Z,                     Z,                     Z,             0, B,            0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, Z,                     Z,                     Z,             0, B,            0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, Z,                     Z,                     Z,             0, B,            0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, Z,                     Z,                     Z,             1, B,            0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1, Z,                     Z,                     Z,             1, B + 64'h4,    0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 1, Z,                     Z,                     Z,             1, B + 64'h8,    0, 0);
    tbl[6]  = mk(0, 1, 1, 0, 0, 1, B + 64'h10,            64'h20,                Z,             1, B + 64'h30,   1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, Z,                     Z,                     Z,             1, B + 64'h34,   0, 0);
    tbl[8]  = mk(0, 1, 1, 1, 0, 1, Z,                     64'h2,                 B + 64'h1003,  1, B + 64'h1004, 1, 0);
    tbl[9]  = mk(0, 1, 1, 1, 0, 1, Z,                     64'h1,                 B + 64'h1001,  1, B + 64'h1002, 1, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, Z,                     Z,                     Z,             1, B + 64'h1006, 0, 0);
    tbl[11] = mk(0, 0, 1, 0, 0, 1, B,                     64'h100,               Z,             1, B + 64'h100A, 0, 0);
    tbl[12] = mk(0, 1, 1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20,              Z,             1, 64'h10,       1, 0);
    tbl[13] = mk(0, 1, 1, 0, 0, 1, B + 64'h100,           64'hFFFF_FFFF_FFFF_FFF8, Z,           1, B + 64'hF8,   1, 0);
    tbl[14] = mk(0, 1, 1, 0, 0, 0, B,                     64'h400,               Z,             1, B + 64'hF8,   1, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, Z,                     Z,                     Z,             1, B + 64'hF8,   0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 1, Z,                     Z,                     Z,             1, B + 64'h400,  0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 1, Z,                     Z,                     Z,             1, B + 64'h404,  0, 0);
    tbl[18] = mk(0, 0, 0, 0, 1, 1, Z,                     Z,                     Z,             0, B + 64'h404,  0, 0);
    tbl[19] = mk(0, 1, 1, 0, 1, 0, B + 64'h100,           64'h100,               Z,             0, B + 64'h404,  1, 0);
    tbl[20] = mk(0, 0, 0, 0, 1, 0, Z,                     Z,                     Z,             0, B + 64'h404,  0, 0);
    tbl[21] = mk(0, 0, 0, 0, 1, 0, Z,                     Z,                     Z,             0, B + 64'h404,  0, 0);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, Z,                     Z,                     Z,             1, B + 64'h200,  0, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 1, Z,                     Z,                     Z,             1, B + 64'h204,  0, 0);
    tbl[24] = mk(0, 0, 0, 0, 1, 1, Z,                     Z,                     Z,             0, B + 64'h204,  0, 0);
    tbl[25] = mk(0, 1, 1, 1, 0, 0, Z,                     64'h4,                 B + 64'h3000,  1, B + 64'h3004, 1, 0);
    tbl[26] = mk(0, 1, 1, 0, 0, 0, B,                     64'h500,               Z,             1, B + 64'h3004, 1, 0);
    tbl[27] = mk(1, 1, 1, 0, 0, 0, B,                     64'h600,               Z,             0, B,            0, 0);
    tbl[28] = mk(0, 0, 0, 0, 0, 0, Z,                     Z,                     Z,             1, B,            0, 0);
    tbl[29] = mk(0, 0, 0, 0, 0, 1, Z,                     Z,                     Z,             1, B + 64'h4,    0, 0);

    for (int i = 0; i < 30; i++) run_vec(tbl[i], i);

    // Outstanding request at 0x8000_0008 left unacked for 3 cycles; redirect arrives in the second.
    seq[0] = mk(1, 0, 0, 0, 0, 0, Z, Z,       Z, 0, B,            0, 0);
    seq[1] = mk(0, 0, 0, 0, 0, 0, Z, Z,       Z, 1, B,            0, 0);
    seq[2] = mk(0, 0, 0, 0, 0, 1, Z, Z,       Z, 1, B + 64'h4,    0, 0);
    seq[3] = mk(0, 0, 0, 0, 0, 1, Z, Z,       Z, 1, B + 64'h8,    0, 0);
    seq[4] = mk(0, 0, 0, 0, 0, 0, Z, Z,       Z, 1, B + 64'h8,    0, 0);
    seq[5] = mk(0, 1, 1, 0, 0, 0, B, 64'h100, Z, 1, B + 64'h8,    1, 0);
    seq[6] = mk(0, 0, 0, 0, 0, 0, Z, Z,       Z, 1, B + 64'h8,    0, 0);
    seq[7] = mk(0, 0, 0, 0, 0, 1, Z, Z,       Z, 1, B + 64'h100,  0, 0);
    seq[8] = mk(0, 0, 0, 0, 0, 1, Z, Z,       Z, 1, B + 64'h104,  0, 0);
    seq[9] = mk(0, 1, 1, 1, 0, 1, Z, 64'h3,   B, 1, B + 64'h2,    1, 1);

    for (int i = 0; i < 10; i++) run_vec(seq[i], 100 + i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22040386_pc_unit.md
# ysyx_22040386_pc_unit

Program-counter stage of the NPC core. Holds the architectural fetch PC, issues fetch requests to the IFU over a req/ack handshake, and consumes the taken-branch decision from the branch-judge stage to redirect fetch. Computes branch/JAL/JALR targets, buffers a redirect that arrives while a fetch is outstanding, and raises flush and misalignment pulses toward the pipeline.

## Interface
- XLEN, 64, datapath width
- RESET_PC, 64'h8000_0000, first fetch address after reset

- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  execute-stage instruction valid this cycle; qualifies Branch
- Branch  in  1  taken decision from branch judge (covers B-type, JAL, JALR)
- Jalr  in  1  execute instruction is JALR
- pc_ex  in  XLEN  PC of execute-stage instruction
- imm_ex  in  XLEN  sign-extended immediate
- rs1_ex  in  XLEN  rs1 operand (JALR base)
- stall  in  1  pipeline hold; PC must not advance while high
- ifu_ack  in  1  IFU accepted the current request
- ifu_req  out  1  fetch request valid
- ifu_addr  out  XLEN  fetch address; equals pc
- pc  out  XLEN  current fetch PC
- flush  out  1  one-cycle pulse: discard younger in-flight instructions
- misalign  out  1  one-cycle pulse: redirect target not 4-byte aligned

## Operation
- taken = ex_valid & Branch. Target = Jalr ? ((rs1_ex + imm_ex) & ~1) : (pc_ex + imm_ex); modulo 2^XLEN, no overflow detection.
- next_seq = redir_v ? redir_pc : pc + 4.
- FSM states: BOOT, REQ, HOLD.
  - BOOT: ifu_req=0. Always -> REQ next cycle.
  - REQ: ifu_req=1. ifu_ack&!stall: pc<=taken?target:next_seq, stay REQ. ifu_ack&stall: pc unchanged, -> HOLD. !ifu_ack: stay.
  - HOLD: ifu_req=0. !stall: pc<=taken?target:next_seq, -> REQ. stall: stay.
- Redirect buffer (redir_v, redir_pc): taken in any cycle where pc is not updated this edge -> redir_v<=1, redir_pc<=target. A newer taken overwrites older pending one. Cleared on the edge pc consumes it.
- taken on the same edge pc updates: target used directly; buffer cleared.
- Handshake: while ifu_req=1 and ifu_ack=0, ifu_addr is held stable; a redirect never alters an outstanding request.
- flush: registered; high the cycle after any taken, one cycle per taken.
- misalign: registered alongside flush when target[1:0]!=0. Redirect still performed; trap handling is downstream.
- Reset values: pc=ifu_addr=RESET_PC, ifu_req=0, flush=0, misalign=0, state=BOOT, redir_v=0.
- rst mid-operation: outstanding request abandoned (ifu_req low next cycle), pending redirect discarded, no flush pulse.

## Timing
- Reset release -> first ifu_req at cycle +1 (BOOT cycle), address RESET_PC.
- Back-to-back fetch: one request per cycle when ifu_ack held high and stall low.
- Branch-to-fetch latency: taken at cycle N with ack -> ifu_addr=target at N+1; without ack -> target issued the cycle after the ack edge.
- stall and taken same cycle in HOLD: buffered, issued on first cycle after stall drops +1.
- taken while ex_valid=0: ignored entirely.

## Structure
- Shared package ysyx_22040386_pkg: XLEN, RESET_PC, INST_BYTES=4, FSM state encoding (BOOT=2'd0, REQ=2'd1, HOLD=2'd2).
- Sub-module ysyx_22040386_pc_target: purely combinational target adder + JALR LSB clear + misalign detect; the top holds FSM, pc register, redirect buffer, pulses.

## Test plan
- Reset: rst high 3 cycles then low -> ifu_req=0 cycle 0, ifu_req=1 with ifu_addr=0x8000_0000 cycle 1; ack every cycle -> 0x8000_0004, 0x8000_0008.
- Taken B-type with ack: pc_ex=0x8000_0010, imm=0x20 -> next ifu_addr 0x8000_0030, flush pulses one cycle.
- JALR: rs1=0x8000_1003, imm=0x2, Jalr=1 -> target 0x8000_1004 (LSB cleared), misalign=0; rs1=0x8000_1001, imm=1 -> 0x8000_1002, misalign=1.
- Redirect during outstanding fetch: req to 0x8000_0008 unacked 3 cycles, taken to 0x8000_0100 in cycle 1 -> ifu_addr stays 0x8000_0008 until ack, then 0x8000_0100.
- Stall: ack with stall high for 4 cycles and a taken to 0x8000_0200 during it -> ifu_req=0, pc frozen; after release ifu_addr=0x8000_0200.
- Reset mid-fetch with redirect pending -> next request 0x8000_0000, no flush, redir_v=0.
